// File: rtl/pong_physics_engine.sv
// pong_physics_engine: frame-rate physics for five balls and two player scores.
// Each frame tick walks every ball through MOVE, WALL, PAD and EDGE. Results
// collect in shadow registers and are committed to the outputs in one cycle.
// Optional macro PHYSICS_SPEEDUP_EN: each paddle reflection also raises |vx|
// by one, capped at VMAX.
module pong_physics_engine #(
  parameter int WIDTH       = 640,
  parameter int HEIGHT      = 480,
  parameter int BALL_RADIUS = 6,
  parameter int PAD_HALF_W  = 4,
  parameter int PAD_HALF_H  = 40,
  parameter int INIT_VX     = 3,
  parameter int INIT_VY     = 2,
  parameter int VMAX        = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               tick,
  input  logic signed [10:0] paddle10_posx,
  input  logic signed [10:0] paddle10_posy,
  input  logic signed [10:0] paddle11_posx,
  input  logic signed [10:0] paddle11_posy,
  input  logic signed [10:0] paddle20_posx,
  input  logic signed [10:0] paddle20_posy,
  input  logic signed [10:0] paddle21_posx,
  input  logic signed [10:0] paddle21_posy,
  output logic signed [10:0] ball1_posx,
  output logic signed [10:0] ball1_posy,
  output logic signed [10:0] ball1_velx,
  output logic signed [10:0] ball1_vely,
  output logic signed [10:0] ball2_posx,
  output logic signed [10:0] ball2_posy,
  output logic signed [10:0] ball2_velx,
  output logic signed [10:0] ball2_vely,
  output logic signed [10:0] ball3_posx,
  output logic signed [10:0] ball3_posy,
  output logic signed [10:0] ball3_velx,
  output logic signed [10:0] ball3_vely,
  output logic signed [10:0] ball4_posx,
  output logic signed [10:0] ball4_posy,
  output logic signed [10:0] ball4_velx,
  output logic signed [10:0] ball4_vely,
  output logic signed [10:0] ball5_posx,
  output logic signed [10:0] ball5_posy,
  output logic signed [10:0] ball5_velx,
  output logic signed [10:0] ball5_vely,
  output logic        [8:0]  Play1_S,
  output logic        [8:0]  Play2_S,
  output logic               busy,
  output logic               done,
  output logic               overrun
);

  localparam logic signed [11:0] R       = 12'(BALL_RADIUS);
  localparam logic signed [11:0] X_HI    = 12'(WIDTH - 1 - BALL_RADIUS);
  localparam logic signed [11:0] Y_HI    = 12'(HEIGHT - 1 - BALL_RADIUS);
  localparam logic signed [11:0] REACH_X = 12'(BALL_RADIUS + PAD_HALF_W);
  localparam logic signed [11:0] REACH_Y = 12'(BALL_RADIUS + PAD_HALF_H);
  localparam logic signed [11:0] VCAP    = 12'(VMAX);
  localparam logic signed [10:0] V0X     = 11'(INIT_VX);
  localparam logic signed [10:0] V0Y     = 11'(INIT_VY);
  localparam logic signed [10:0] CENTER_X = 11'sd320;
`ifdef PHYSICS_SPEEDUP_EN
  localparam logic signed [11:0] SPEED_INC = 12'sd1;
`else
  localparam logic signed [11:0] SPEED_INC = 12'sd0;
`endif

  typedef enum logic [2:0] {S_IDLE, S_MOVE, S_WALL, S_PAD, S_EDGE, S_COMMIT} state_t;

  state_t state;
  logic [2:0] idx;
  logic signed [11:0] nx, ny, wvx, wvy;

  logic signed [10:0] sh_px [5];
  logic signed [10:0] sh_py [5];
  logic signed [10:0] sh_vx [5];
  logic signed [10:0] sh_vy [5];
  logic signed [10:0] o_px  [5];
  logic signed [10:0] o_py  [5];
  logic signed [10:0] o_vx  [5];
  logic signed [10:0] o_vy  [5];
  logic [8:0] sh_s1, sh_s2, o_s1, o_s2;

  logic signed [11:0] pad_x [4];
  logic signed [11:0] pad_y [4];
  logic hit_left, hit_right, do_reflect;
  logic signed [11:0] mag, mag_n, capped, refl_vx;

  // Ball K respawns at row 80*K; idx is K-1.
  function automatic logic signed [10:0] spawn_y(input logic [2:0] k);
    int row;
    row = 80 * (int'(k) + 1);
    return 11'(row);
  endfunction

  function automatic logic [8:0] sat_inc(input logic [8:0] s);
    return (s == 9'h1FF) ? s : s + 9'd1;
  endfunction

  assign pad_x[0] = {paddle10_posx[10], paddle10_posx};
  assign pad_y[0] = {paddle10_posy[10], paddle10_posy};
  assign pad_x[1] = {paddle11_posx[10], paddle11_posx};
  assign pad_y[1] = {paddle11_posy[10], paddle11_posy};
  assign pad_x[2] = {paddle20_posx[10], paddle20_posx};
  assign pad_y[2] = {paddle20_posy[10], paddle20_posy};
  assign pad_x[3] = {paddle21_posx[10], paddle21_posx};
  assign pad_y[3] = {paddle21_posy[10], paddle21_posy};

  // Paddle overlap against the live paddle inputs and the reflected velocity.
  always_comb begin
    logic signed [11:0] dx, dy, adx, ady;
    dx = '0; dy = '0; adx = '0; ady = '0;
    hit_left  = 1'b0;
    hit_right = 1'b0;
    for (int p = 0; p < 4; p++) begin
      dx  = nx - pad_x[p];
      dy  = ny - pad_y[p];
      adx = (dx < 0) ? -dx : dx;
      ady = (dy < 0) ? -dy : dy;
      if (adx <= REACH_X && ady <= REACH_Y) begin
        if (p < 2) hit_left = 1'b1;
        else       hit_right = 1'b1;
      end
    end
    do_reflect = (hit_left && wvx < 0) || (hit_right && wvx > 0);
    mag     = (wvx < 0) ? -wvx : wvx;
    mag_n   = mag + SPEED_INC;
    capped  = (SPEED_INC != 0 && mag_n > VCAP) ? VCAP : mag_n;
    refl_vx = (wvx < 0) ? capped : -capped;
  end

  // Frame sequencer: per-ball physics steps, shadow updates and the commit.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state   <= S_IDLE;
      idx     <= '0;
      nx      <= '0;
      ny      <= '0;
      wvx     <= '0;
      wvy     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      overrun <= 1'b0;
      sh_s1   <= '0;
      sh_s2   <= '0;
      o_s1    <= '0;
      o_s2    <= '0;
      for (int k = 0; k < 5; k++) begin
        sh_px[k] <= CENTER_X;
        sh_py[k] <= spawn_y(3'(k));
        sh_vx[k] <= (k[0] == 1'b0) ? V0X : -V0X;
        sh_vy[k] <= (k[0] == 1'b0) ? V0Y : -V0Y;
        o_px[k]  <= CENTER_X;
        o_py[k]  <= spawn_y(3'(k));
        o_vx[k]  <= (k[0] == 1'b0) ? V0X : -V0X;
        o_vy[k]  <= (k[0] == 1'b0) ? V0Y : -V0Y;
      end
    end else begin
      done <= 1'b0;
      if (tick && state != S_IDLE) overrun <= 1'b1;
      case (state)
        S_IDLE: begin
          if (tick) begin
            state <= S_MOVE;
            idx   <= '0;
            busy  <= 1'b1;
          end
        end
        S_MOVE: begin
          nx    <= {sh_px[idx][10], sh_px[idx]} + {sh_vx[idx][10], sh_vx[idx]};
          ny    <= {sh_py[idx][10], sh_py[idx]} + {sh_vy[idx][10], sh_vy[idx]};
          wvx   <= {sh_vx[idx][10], sh_vx[idx]};
          wvy   <= {sh_vy[idx][10], sh_vy[idx]};
          state <= S_WALL;
        end
        S_WALL: begin
          if (ny < R) begin
            ny  <= R;
            wvy <= -wvy;
          end else if (ny > Y_HI) begin
            ny  <= Y_HI;
            wvy <= -wvy;
          end
          state <= S_PAD;
        end
        S_PAD: begin
          if (do_reflect) wvx <= refl_vx;
          state <= S_EDGE;
        end
        S_EDGE: begin
          sh_py[idx] <= ny[10:0];
          sh_vy[idx] <= wvy[10:0];
          if (nx < R) begin
            sh_s2      <= sat_inc(sh_s2);
            sh_px[idx] <= CENTER_X;
            sh_py[idx] <= spawn_y(idx);
            sh_vx[idx] <= V0X;
          end else if (nx > X_HI) begin
            sh_s1      <= sat_inc(sh_s1);
            sh_px[idx] <= CENTER_X;
            sh_py[idx] <= spawn_y(idx);
            sh_vx[idx] <= -V0X;
          end else begin
            sh_px[idx] <= nx[10:0];
            sh_vx[idx] <= wvx[10:0];
          end
          if (idx == 3'd4) begin
            state <= S_COMMIT;
          end else begin
            idx   <= idx + 3'd1;
            state <= S_MOVE;
          end
        end
        S_COMMIT: begin
          o_px  <= sh_px;
          o_py  <= sh_py;
          o_vx  <= sh_vx;
          o_vy  <= sh_vy;
          o_s1  <= sh_s1;
          o_s2  <= sh_s2;
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign ball1_posx = o_px[0];
  assign ball1_posy = o_py[0];
  assign ball1_velx = o_vx[0];
  assign ball1_vely = o_vy[0];
  assign ball2_posx = o_px[1];
  assign ball2_posy = o_py[1];
  assign ball2_velx = o_vx[1];
  assign ball2_vely = o_vy[1];
  assign ball3_posx = o_px[2];
  assign ball3_posy = o_py[2];
  assign ball3_velx = o_vx[2];
  assign ball3_vely = o_vy[2];
  assign ball4_posx = o_px[3];
  assign ball4_posy = o_py[3];
  assign ball4_velx = o_vx[3];
  assign ball4_vely = o_vy[3];
  assign ball5_posx = o_px[4];
  assign ball5_posy = o_py[4];
  assign ball5_velx = o_vx[4];
  assign ball5_vely = o_vy[4];
  assign Play1_S    = o_s1;
  assign Play2_S    = o_s2;

endmodule

// File: tb/tb_pong_physics_engine.sv
// tb_pong_physics_engine: directed scenarios for pong_physics_engine with
// hand-computed expectations for reset, stepping, walls, paddles, goals and
// overrun handling.
module tb_pong_physics_engine;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic tick = 1'b0;
  logic signed [10:0] paddle10_posx, paddle10_posy, paddle11_posx, paddle11_posy;
  logic signed [10:0] paddle20_posx, paddle20_posy, paddle21_posx, paddle21_posy;
  logic signed [10:0] ball1_posx, ball1_posy, ball1_velx, ball1_vely;
  logic signed [10:0] ball2_posx, ball2_posy, ball2_velx, ball2_vely;
  logic signed [10:0] ball3_posx, ball3_posy, ball3_velx, ball3_vely;
  logic signed [10:0] ball4_posx, ball4_posy, ball4_velx, ball4_vely;
  logic signed [10:0] ball5_posx, ball5_posy, ball5_velx, ball5_vely;
  logic [8:0] Play1_S, Play2_S;
  logic busy, done, overrun;

  int vectors = 0;
  int miscompares = 0;

  pong_physics_engine dut (
    .clk(clk), .rst_n(rst_n), .tick(tick),
    .paddle10_posx(paddle10_posx), .paddle10_posy(paddle10_posy),
    .paddle11_posx(paddle11_posx), .paddle11_posy(paddle11_posy),
    .paddle20_posx(paddle20_posx), .paddle20_posy(paddle20_posy),
    .paddle21_posx(paddle21_posx), .paddle21_posy(paddle21_posy),
    .ball1_posx(ball1_posx), .ball1_posy(ball1_posy), .ball1_velx(ball1_velx), .ball1_vely(ball1_vely),
    .ball2_posx(ball2_posx), .ball2_posy(ball2_posy), .ball2_velx(ball2_velx), .ball2_vely(ball2_vely),
    .ball3_posx(ball3_posx), .ball3_posy(ball3_posy), .ball3_velx(ball3_velx), .ball3_vely(ball3_vely),
    .ball4_posx(ball4_posx), .ball4_posy(ball4_posy), .ball4_velx(ball4_velx), .ball4_vely(ball4_vely),
    .ball5_posx(ball5_posx), .ball5_posy(ball5_posy), .ball5_velx(ball5_velx), .ball5_vely(ball5_vely),
    .Play1_S(Play1_S), .Play2_S(Play2_S),
    .busy(busy), .done(done), .overrun(overrun)
  );

  // Free-running 10 ns clock.
  always #5 clk = ~clk;

  // Watchdog so the run always ends even if a bounded loop is bypassed.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  task automatic park_paddles;
    paddle10_posx = -11'sd200; paddle10_posy = 11'sd240;
    paddle11_posx = -11'sd200; paddle11_posy = 11'sd240;
    paddle20_posx = -11'sd200; paddle20_posy = 11'sd240;
    paddle21_posx = -11'sd200; paddle21_posy = 11'sd240;
  endtask

  task automatic apply_reset;
    tick = 1'b0;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
  endtask

  // One tick, then wait (bounded) for done; cycles = edges from acceptance, 0 on timeout.
  task automatic run_frame(output int cycles);
    @(negedge clk);
    tick = 1'b1;
    @(posedge clk);
    #1 tick = 1'b0;
    cycles = 0;
    for (int j = 1; j <= 50; j++) begin
      @(posedge clk);
      #1;
      if (done) begin
        cycles = j;
        break;
      end
    end
  endtask

  task automatic run_frames(input int n, output int timeouts);
    int c;
    timeouts = 0;
    for (int i = 0; i < n; i++) begin
      run_frame(c);
      if (c == 0) timeouts++;
    end
  endtask

  task automatic test_reset;
    park_paddles();
    apply_reset();
    vectors++; if (ball3_posx !== 11'sd320) begin miscompares++; $display("[TB] FAIL rst_b3x got %0d want 320", ball3_posx); end
    vectors++; if (ball3_posy !== 11'sd240) begin miscompares++; $display("[TB] FAIL rst_b3y got %0d want 240", ball3_posy); end
    vectors++; if (ball3_velx !== 11'sd3 || ball3_vely !== 11'sd2) begin miscompares++; $display("[TB] FAIL rst_b3v got %0d,%0d want 3,2", ball3_velx, ball3_vely); end
    vectors++; if (ball4_posx !== 11'sd320 || ball4_posy !== 11'sd320) begin miscompares++; $display("[TB] FAIL rst_b4p got %0d,%0d want 320,320", ball4_posx, ball4_posy); end
    vectors++; if (ball4_velx !== -11'sd3 || ball4_vely !== -11'sd2) begin miscompares++; $display("[TB] FAIL rst_b4v got %0d,%0d want -3,-2", ball4_velx, ball4_vely); end
    vectors++; if (Play1_S !== 9'd0 || Play2_S !== 9'd0) begin miscompares++; $display("[TB] FAIL rst_scores got %0d,%0d want 0,0", Play1_S, Play2_S); end
    vectors++; if ({busy, done, overrun} !== 3'b000) begin miscompares++; $display("[TB] FAIL rst_flags got %b want 000", {busy, done, overrun}); end
  endtask

  task automatic test_single_step;
    int first_done;
    int early_x;
    park_paddles();
    apply_reset();
    first_done = 0;
    early_x = 0;
    @(negedge clk);
    tick = 1'b1;
    @(posedge clk);
    #1 tick = 1'b0;
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("[TB] FAIL step_busy got %b want 1", busy); end
    for (int j = 1; j <= 40; j++) begin
      @(posedge clk);
      #1;
      if (j == 20) early_x = int'(ball1_posx);
      if (done && first_done == 0) first_done = j;
      if (first_done != 0) break;
    end
    vectors++; if (first_done != 21) begin miscompares++; $display("[TB] FAIL step_latency got %0d want 21", first_done); end
    vectors++; if (early_x != 320) begin miscompares++; $display("[TB] FAIL step_early_x got %0d want 320", early_x); end
    vectors++; if (ball1_posx !== 11'sd323 || ball1_posy !== 11'sd82) begin miscompares++; $display("[TB] FAIL step_b1 got %0d,%0d want 323,82", ball1_posx, ball1_posy); end
    vectors++; if (ball2_posx !== 11'sd317 || ball2_posy !== 11'sd158) begin miscompares++; $display("[TB] FAIL step_b2 got %0d,%0d want 317,158", ball2_posx, ball2_posy); end
    @(posedge clk);
    #1;
    vectors++; if (done !== 1'b0 || busy !== 1'b0) begin miscompares++; $display("[TB] FAIL step_after got done=%b busy=%b want 0,0", done, busy); end
  endtask

  task automatic test_wall_bounce;
    int t;
    park_paddles();
    apply_reset();
    run_frames(77, t);
    vectors++; if (ball2_posy !== 11'sd6 || ball2_vely !== -11'sd2) begin miscompares++; $display("[TB] FAIL wall_77 got %0d,%0d want 6,-2", ball2_posy, ball2_vely); end
    run_frames(1, t);
    vectors++; if (ball2_posy !== 11'sd6 || ball2_vely !== 11'sd2) begin miscompares++; $display("[TB] FAIL wall_78 got %0d,%0d want 6,2", ball2_posy, ball2_vely); end
    vectors++; if (t != 0) begin miscompares++; $display("[TB] FAIL wall_timeout got %0d want 0", t); end
  endtask

  task automatic test_paddle_hit;
    int t;
    logic signed [10:0] exp_vx, exp_x38;
`ifdef PHYSICS_SPEEDUP_EN
    exp_vx = 11'sd4; exp_x38 = 11'sd213;
`else
    exp_vx = 11'sd3; exp_x38 = 11'sd212;
`endif
    park_paddles();
    paddle10_posx = 11'sd200;
    paddle10_posy = 11'sd100;
    apply_reset();
    run_frames(36, t);
    vectors++; if (ball2_posx !== 11'sd212 || ball2_velx !== -11'sd3) begin miscompares++; $display("[TB] FAIL pad_36 got %0d,%0d want 212,-3", ball2_posx, ball2_velx); end
    run_frames(1, t);
    vectors++; if (ball2_posx !== 11'sd209 || ball2_posy !== 11'sd86) begin miscompares++; $display("[TB] FAIL pad_37_pos got %0d,%0d want 209,86", ball2_posx, ball2_posy); end
    vectors++; if (ball2_velx !== exp_vx) begin miscompares++; $display("[TB] FAIL pad_37_vx got %0d want %0d", ball2_velx, exp_vx); end
    run_frames(1, t);
    vectors++; if (ball2_posx !== exp_x38) begin miscompares++; $display("[TB] FAIL pad_38_x got %0d want %0d", ball2_posx, exp_x38); end
  endtask

  task automatic test_goals;
    int t1, t2;
    park_paddles();
    apply_reset();
    run_frames(104, t1);
    vectors++; if (Play1_S !== 9'd0 || Play2_S !== 9'd0 || ball1_posx !== 11'sd632) begin miscompares++; $display("[TB] FAIL goal_104 got s=%0d,%0d x=%0d want 0,0,632", Play1_S, Play2_S, ball1_posx); end
    run_frames(1, t2);
    vectors++; if (Play1_S !== 9'd3 || Play2_S !== 9'd2) begin miscompares++; $display("[TB] FAIL goal_scores got %0d,%0d want 3,2", Play1_S, Play2_S); end
    vectors++; if (ball1_posx !== 11'sd320 || ball1_posy !== 11'sd80 || ball1_velx !== -11'sd3 || ball1_vely !== 11'sd2) begin miscompares++; $display("[TB] FAIL goal_b1 got %0d,%0d,%0d,%0d want 320,80,-3,2", ball1_posx, ball1_posy, ball1_velx, ball1_vely); end
    vectors++; if (ball2_posx !== 11'sd320 || ball2_posy !== 11'sd160 || ball2_velx !== 11'sd3) begin miscompares++; $display("[TB] FAIL goal_b2 got %0d,%0d,%0d want 320,160,3", ball2_posx, ball2_posy, ball2_velx); end
    vectors++; if (overrun !== 1'b0 || t1 + t2 != 0) begin miscompares++; $display("[TB] FAIL goal_clean got ovr=%b timeouts=%0d want 0,0", overrun, t1 + t2); end
  endtask

  task automatic test_overrun;
    int pulses;
    park_paddles();
    apply_reset();
    pulses = 0;
    @(negedge clk);
    tick = 1'b1;
    @(posedge clk);
    #1 tick = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    tick = 1'b1;
    @(posedge clk);
    #1 tick = 1'b0;
    for (int j = 0; j < 60; j++) begin
      @(posedge clk);
      #1;
      if (done) pulses++;
    end
    vectors++; if (pulses != 1) begin miscompares++; $display("[TB] FAIL ovr_pulses got %0d want 1", pulses); end
    vectors++; if (overrun !== 1'b1) begin miscompares++; $display("[TB] FAIL ovr_flag got %b want 1", overrun); end
    vectors++; if (ball1_posx !== 11'sd323) begin miscompares++; $display("[TB] FAIL ovr_b1x got %0d want 323", ball1_posx); end
  endtask

  task automatic test_back_to_back;
    int c1, c2;
    park_paddles();
    apply_reset();
    run_frame(c1);
    run_frame(c2);
    vectors++; if (c1 != 21 || c2 != 21) begin miscompares++; $display("[TB] FAIL b2b_latency got %0d,%0d want 21,21", c1, c2); end
    vectors++; if (ball1_posx !== 11'sd326 || overrun !== 1'b0) begin miscompares++; $display("[TB] FAIL b2b_state got x=%0d ovr=%b want 326,0", ball1_posx, overrun); end
  endtask

  task automatic test_reset_midframe;
    int c;
    park_paddles();
    apply_reset();
    @(negedge clk);
    tick = 1'b1;
    @(posedge clk);
    #1 tick = 1'b0;
    repeat (10) @(posedge clk);
    apply_reset();
    vectors++; if (busy !== 1'b0 || ball1_posx !== 11'sd320) begin miscompares++; $display("[TB] FAIL mid_rst got busy=%b x=%0d want 0,320", busy, ball1_posx); end
    run_frame(c);
    vectors++; if (c != 21 || ball1_posx !== 11'sd323) begin miscompares++; $display("[TB] FAIL mid_frame got lat=%0d x=%0d want 21,323", c, ball1_posx); end
  endtask

  // Scenario sequence followed by the single summary line.
  initial begin
    $display("[TB] start");
    test_reset();
    test_single_step();
    test_wall_bounce();
    test_paddle_hit();
    test_goals();
    test_overrun();
    test_back_to_back();
    test_reset_midframe();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pong_physics_engine.md
Name: pong_physics_engine

Overview:
- Frame-rate physics stage that sits directly upstream of the VGA renderer and feeds it.
- Owns the state of 5 balls and both player scores. Paddle positions come from the paddle/input logic.
- On each frame tick it steps every ball in turn: move, wall bounce, paddle reflection, goal detection and respawn.
- Results go to shadow registers and are committed to the outputs all at once, so the renderer never sees a half-updated frame.

Parameters:
- WIDTH, 640: playfield width in pixels.
- HEIGHT, 480: playfield height in pixels.
- BALL_RADIUS, 6: ball half-extent; the ball is drawn as a square.
- PAD_HALF_W, 4: paddle half-width.
- PAD_HALF_H, 40: paddle half-height.
- INIT_VX, 3: serve horizontal speed magnitude.
- INIT_VY, 2: serve vertical speed magnitude.
- VMAX, 8: horizontal speed cap (used only by the optional feature).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous reset, active-high despite the suffix.
- tick  in  1  one-cycle frame pulse.
- paddleNM_posx / paddleNM_posy  in  11 signed  paddle centres, NM in {10,11,20,21}. 1x is the left player (P1); 2x is the right player (P2).
- ballK_posx / ballK_posy  out  11 signed  ball centres, K=1..5.
- ballK_velx / ballK_vely  out  11 signed  ball velocities, K=1..5.
- Play1_S / Play2_S  out  9  player scores.
- busy  out  1  high from the cycle after tick acceptance through COMMIT.
- done  out  1  one-cycle pulse on COMMIT.
- overrun  out  1  sticky flag; a tick arrived while busy.

Behaviour:
- Reset values:
  - ballK_posx = 320; ballK_posy = 80*K.
  - Odd K: velx = +INIT_VX, vely = +INIT_VY.
  - Even K: velx = -INIT_VX, vely = -INIT_VY.
  - Scores = 0; busy, done and overrun = 0; FSM in IDLE; shadow registers equal the outputs.
  - Reset asserted mid-operation abandons the frame and restores all of the above.
- FSM: IDLE -> (MOVE -> WALL -> PAD -> EDGE) for ball index 0..4 -> COMMIT -> IDLE.
  - One state per cycle, so 20 processing cycles.
  - tick sampled in IDLE at edge k gives COMMIT at edge k+21.
  - Outputs and done update on that same edge.
- MOVE: nx = px + vx and ny = py + vy, in 12-bit signed internal width. Positions stay within 11 bits after clamping.
- WALL:
  - If ny - R < 0: ny = R and vy = -vy.
  - Else if ny + R > HEIGHT-1: ny = HEIGHT-1-R and vy = -vy.
- PAD:
  - Overlap test per paddle: |nx - padx| <= R + PAD_HALF_W and |ny - pady| <= R + PAD_HALF_H, compared signed.
  - A left paddle reflects only when vx < 0; a right paddle reflects only when vx > 0. Reflection sets vx = -vx.
  - Multiple overlapping paddles cause one reflection only.
  - Position is unchanged by a reflection.
- EDGE:
  - If nx - R < 0: P2 scores. If nx + R > WIDTH-1: P1 scores.
  - On a goal the ball respawns at (320, 80*K). velx = +INIT_VX after a left exit, -INIT_VX after a right exit; vely is kept.
  - Scores saturate at 511.
  - Goals are checked after PAD in the same frame.
- tick while busy or in COMMIT: ignored and overrun set. overrun clears only on reset.
- tick in IDLE the cycle after COMMIT is accepted normally.
- Paddle inputs are sampled live during PAD and need not be stable across the frame.

Optional Feature:
- Macro PHYSICS_SPEEDUP_EN.
- Defined: every paddle reflection also increments |vx| by 1, capped at VMAX; the sign follows the new direction. Respawn resets |vx| to INIT_VX.
- Undefined: reflection only negates vx; |vx| never changes.

Test Plan:
- Reset check -> ball3 = (320,240,+3,+2), ball4 = (320,320,-3,-2); scores 0; busy, done, overrun 0.
- Single step:
  - Stimulus: paddles parked at x=-200, one tick.
  - Response: done exactly 21 cycles after tick.
  - Response: ball1 = (323,82), ball2 = (317,158).
  - Response: outputs unchanged before done.
- Wall bounce:
  - Stimulus: paddles parked, 78 ticks.
  - Response: ball2 posy = 6, vely = +2 (after tick 77 posy is 6 and vely is -2).
- Paddle hit:
  - Stimulus: paddle10 = (200,100), other paddles parked, 37 ticks.
  - Response: ball2 = (209,86) with velx = +3 (+4 with PHYSICS_SPEEDUP_EN).
  - Response: tick 38 gives posx = 212.
- Goals:
  - Stimulus: all paddles parked, 105 ticks.
  - Response: Play1_S = 3, Play2_S = 2.
  - Response: ball1 = (320,80,velx -3), ball2 = (320,160,velx +3).
- Overrun: second tick 5 cycles after the first -> overrun = 1, only one position step applied, done pulses once.
